step_clock_gen: RTL and testbench



---
 rtl/step_clock_gen.sv | 199 +++++++++++++++++++
 tb/tb_step_clock_gen.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_clock_gen.sv
// step_clock_gen: debounced single-step / prescaled free-run clock for the CPU core.
// Optional STEP_PEND_EN adds a one-deep pending request so back-to-back steps skip IDLE.
module step_clock_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HIGH_CYCLES     = 4,
  parameter int unsigned LOW_CYCLES      = 4,
  parameter int unsigned RUN_DIV         = 50000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_raw,
  input  logic        run_mode,
  input  logic [1:0]  rate_sel,
  output logic        cpu_clk,
  output logic        busy,
  output logic [15:0] step_count
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned PH_MAX = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
  localparam int unsigned PRE_W  = $clog2(RUN_DIV + 1);

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PH_W-1:0]  HIGH_LAST = PH_W'(HIGH_CYCLES - 1);
  localparam logic [PH_W-1:0]  LOW_LAST  = PH_W'(LOW_CYCLES - 1);
  localparam logic [PRE_W-1:0] RUN_DIV_W = PRE_W'(RUN_DIV);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_level_q, db_level_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             press_q, press_d;
  logic [1:0]       rate_sel_q, rate_sel_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [1:0]       state_q, state_d;
  logic [PH_W-1:0]  ph_cnt_q, ph_cnt_d;
  logic             cpu_clk_q, cpu_clk_d;
  logic             busy_q, busy_d;
  logic [15:0]      step_count_q, step_count_d;

  logic             rate_chg;
  logic [PRE_W-1:0] pre_last;
  logic             pre_hit;
  logic             req;
  logic             chain;

`ifdef STEP_PEND_EN
  logic run_mode_q, run_mode_d;
  logic pend_q, pend_d;
  logic mode_chg;
  logic low_exit;
`endif

  // Synchronizer, debouncer and press one-shot
  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    if (sync2_q != db_level_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_level_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
    press_d = db_level_d & ~db_level_q;
  end

  // Period uses the registered rate so a rate change restarts cleanly from zero.
  always_comb begin
    rate_sel_d = rate_sel;
    rate_chg   = (rate_sel != rate_sel_q);
    pre_last   = (RUN_DIV_W >> {rate_sel_q, 1'b0}) - PRE_W'(1);
    pre_hit    = run_mode && !rate_chg && (pre_cnt_q == pre_last);
    if (!run_mode || rate_chg || (pre_cnt_q == pre_last)) begin
      pre_cnt_d = '0;
    end else begin
      pre_cnt_d = pre_cnt_q + 1'b1;
    end
    req = run_mode ? pre_hit : press_q;
  end

`ifdef STEP_PEND_EN
  always_comb begin
    run_mode_d = run_mode;
    mode_chg   = (run_mode != run_mode_q);
    low_exit   = (state_q == ST_LOW) && (ph_cnt_q == LOW_LAST);
    chain      = low_exit && ((pend_q && !mode_chg) || req);
    if (mode_chg || chain) begin
      pend_d = 1'b0;
    end else if ((state_q != ST_IDLE) && req) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end
`else
  always_comb begin
    chain = 1'b0;
  end
`endif

  // Pulse-shaping FSM
  always_comb begin
    state_d  = state_q;
    ph_cnt_d = ph_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d  = ST_HIGH;
          ph_cnt_d = '0;
        end
      end
      ST_HIGH: begin
        if (ph_cnt_q == HIGH_LAST) begin
          state_d  = ST_LOW;
          ph_cnt_d = '0;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      ST_LOW: begin
        if (ph_cnt_q == LOW_LAST) begin
          state_d  = chain ? ST_HIGH : ST_IDLE;
          ph_cnt_d = '0;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        ph_cnt_d = '0;
      end
    endcase
  end

  // Outputs follow the next state so cpu_clk rises on the edge that enters HIGH.
  always_comb begin
    cpu_clk_d    = (state_d == ST_HIGH);
    busy_d       = (state_d != ST_IDLE);
    step_count_d = step_count_q;
    if (cpu_clk_d && !cpu_clk_q) begin
      step_count_d = step_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      db_level_q   <= 1'b0;
      db_cnt_q     <= '0;
      press_q      <= 1'b0;
      rate_sel_q   <= '0;
      pre_cnt_q    <= '0;
      state_q      <= ST_IDLE;
      ph_cnt_q     <= '0;
      cpu_clk_q    <= 1'b0;
      busy_q       <= 1'b0;
      step_count_q <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      db_level_q   <= db_level_d;
      db_cnt_q     <= db_cnt_d;
      press_q      <= press_d;
      rate_sel_q   <= rate_sel_d;
      pre_cnt_q    <= pre_cnt_d;
      state_q      <= state_d;
      ph_cnt_q     <= ph_cnt_d;
      cpu_clk_q    <= cpu_clk_d;
      busy_q       <= busy_d;
      step_count_q <= step_count_d;
    end
  end

`ifdef STEP_PEND_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_mode_q <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      run_mode_q <= run_mode_d;
      pend_q     <= pend_d;
    end
  end
`endif

  assign cpu_clk    = cpu_clk_q;
  assign busy       = busy_q;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_step_clock_gen.sv
// Scoreboard bench for step_clock_gen: stimulus pushes expected pulses, a monitor
// pops and checks each cpu_clk rise (timing, width, busy, step_count).
module tb_step_clock_gen;
  localparam int DB   = 8;
  localparam int HC   = 4;
  localparam int LC   = 4;
  localparam int RDIV = 64;
`ifdef STEP_PEND_EN
  localparam int B2B_PERIOD = HC + LC;
`else
  localparam int B2B_PERIOD = HC + LC + 1;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        btn_raw = 1'b0;
  logic        run_mode = 1'b0;
  logic [1:0]  rate_sel = 2'd0;
  logic        cpu_clk;
  logic        busy;
  logic [15:0] step_count;

  step_clock_gen #(
    .DEBOUNCE_CYCLES(DB),
    .HIGH_CYCLES(HC),
    .LOW_CYCLES(LC),
    .RUN_DIV(RDIV)
  ) dut (
    .clock(clock),
    .reset(reset),
    .btn_raw(btn_raw),
    .run_mode(run_mode),
    .rate_sel(rate_sel),
    .cpu_clk(cpu_clk),
    .busy(busy),
    .step_count(step_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int lo;
    int hi;
    int delta;
    int width;
    int busy_w;
    int count;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  int   exp_steps = 0;
  bit   mon_busy  = 1'b0;
  logic prev_clk  = 1'b0;
  int   last_rise = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_in(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic push_exp(input int lo, input int hi, input int delta, input int width,
                          input int busy_w);
    exp_t e;
    exp_steps = (exp_steps + 1) % 65536;
    e.lo = lo; e.hi = hi; e.delta = delta;
    e.width = width; e.busy_w = busy_w; e.count = exp_steps;
    exp_q.push_back(e);
  endtask

  // Press held for `hold` clocks: rise expected DB+3 clocks after the edge, +/-1.
  task automatic press(input int hold);
    btn_raw = 1'b1;
    push_exp(cyc + DB + 2, cyc + DB + 4, 0, HC, HC + LC);
    repeat (hold) @(negedge clock);
    btn_raw = 1'b0;
    repeat (DB + 6) @(negedge clock);
  endtask

  task automatic bounce(input int total, input int lo, input int hi);
    int t;
    int r;
    t = 0;
    while (t < total) begin
      btn_raw = ~btn_raw;
      r = int'($urandom_range(hi, lo));
      repeat (r) @(negedge clock);
      t += r;
    end
    btn_raw = 1'b0;
    repeat (DB + 6) @(negedge clock);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(name, exp_q.size() + int'(mon_busy), 0);
  endtask

  initial begin : monitor
    exp_t e;
    int   rise;
    int   hw;
    int   bw;
    bit   h_on;
    bit   b_on;
    forever begin
      @(negedge clock);
      if (cpu_clk && !prev_clk) begin
        mon_busy = 1'b1;
        rise = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: rise at cycle %0d with step_count %0d, expected no pulse",
                   rise, step_count);
          e.width = 0;
          e.busy_w = 0;
        end else begin
          e = exp_q.pop_front();
          if (e.delta > 0) check("rise_interval", rise - last_rise, e.delta);
          else check_in("rise_time", rise, e.lo, e.hi);
          check("step_count_at_rise", int'(step_count), e.count);
          check("busy_at_rise", int'(busy), 1);
        end
        last_rise = rise;
        hw = 1;
        bw = busy ? 1 : 0;
        h_on = 1'b1;
        b_on = busy;
        for (int i = 0; i < 64 && (h_on || (b_on && e.busy_w > 0)); i++) begin
          @(negedge clock);
          if (h_on) begin
            if (cpu_clk) hw++;
            else h_on = 1'b0;
          end
          if (b_on) begin
            if (busy) bw++;
            else b_on = 1'b0;
          end
        end
        if (e.width > 0) check("high_width", hw, e.width);
        if (e.busy_w > 0) check("busy_width", bw, e.busy_w);
        mon_busy = 1'b0;
      end
      prev_clk = cpu_clk;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation ran past its time limit, expected completion");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int k;
    int n;
    repeat (2) @(negedge clock);
    check("reset_cpu_clk", int'(cpu_clk), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_step_count", int'(step_count), 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Clean press, held 50 clocks: exactly one 4-clock pulse.
    press(50);
    wait_drain("drain_clean", 50);
    check("clean_step_count", int'(step_count), exp_steps);

    // Regular bounce every 3 clocks: no step.
    bounce(30, 3, 3);
    check("bounce_no_step", int'(step_count), exp_steps);

    // Random bounces and presses.
    repeat (4) begin
      if ($urandom_range(1, 0) == 1) bounce(int'($urandom_range(40, 10)), 1, DB - 3);
      repeat (int'($urandom_range(10, 1))) @(negedge clock);
      press(int'($urandom_range(60, 20)));
    end
    wait_drain("drain_random", 100);
    check("random_step_count", int'(step_count), exp_steps);

    // Free-run P=16 with ignored button presses.
    run_mode = 1'b1;
    rate_sel = 2'd1;
    k = cyc;
    push_exp(k + 15, k + 18, 0, HC, 0);
    repeat (11) push_exp(0, 0, RDIV >> 2, HC, 0);
    repeat (3) begin
      repeat (int'($urandom_range(15, 5))) @(negedge clock);
      btn_raw = 1'b1;
      repeat (20) @(negedge clock);
      btn_raw = 1'b0;
    end
    wait_drain("drain_freerun", 300);
    run_mode = 1'b0;
    repeat (40) @(negedge clock);
    check("freerun_step_count", int'(step_count), exp_steps);

    // Back-to-back requests, P=1.
    rate_sel = 2'd3;
    repeat (3) @(negedge clock);
    run_mode = 1'b1;
    k = cyc;
    push_exp(k + 1, k + 2, 0, HC, 0);
    repeat (5) push_exp(0, 0, B2B_PERIOD, HC, 0);
    wait_drain("drain_b2b", 200);
    run_mode = 1'b0;
    repeat (30) @(negedge clock);
    check("b2b_step_count", int'(step_count), exp_steps);
    check("b2b_idle_busy", int'(busy), 0);

    // Reset in the middle of a HIGH phase.
    btn_raw = 1'b1;
    push_exp(cyc + DB + 2, cyc + DB + 4, 0, 0, 0);
    n = 0;
    while (!cpu_clk && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("reached_high", int'(cpu_clk), 1);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_reset_cpu_clk", int'(cpu_clk), 0);
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_step_count", int'(step_count), 0);
    exp_steps = 0;
    btn_raw = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    press(30);
    wait_drain("drain_after_reset", 50);
    check("after_reset_step_count", int'(step_count), 1);

    repeat (20) @(negedge clock);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
